// File: rtl/mvm_stream_param.sv
// mvm_stream_param: streaming signed matrix-vector multiplier, y = A*x.
//   A frame is N beats of x, then M*N beats of A in row-major order. If
//   reuse_a is set on the first beat and an A is already stored, the frame is
//   x only. One MAC per cycle; results are range-checked against OW
//   (saturate or wrap) and drained over a valid/ready output handshake.
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   s_valid/s_ready   input beat handshake, data_in = signed DW-bit element
//   reuse_a           sampled on beat 0: keep the stored A for this frame
//   m_valid/m_ready   result handshake, data_out = y[i] (signed OW bits)
//   overflow          data_out was out of the OW range (valid with m_valid)
module mvm_stream_param #(
    parameter int M   = 3,
    parameter int N   = 3,
    parameter int DW  = 8,
    parameter int OW  = 16,
    parameter int SAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] data_in,
    input  logic                 reuse_a,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [OW-1:0] data_out,
    output logic                 overflow
);
    localparam int MN   = M * N;
    localparam int ACCW = 2 * DW + $clog2(N) + 1;
    // compare width that holds both the accumulator and the OW limits
    localparam int EW   = ((ACCW > OW) ? ACCW : OW) + 1;
    localparam int CW   = $clog2(MN + 2) + 1;
    localparam int AW   = (MN > 1) ? $clog2(MN) : 1;
    localparam int XW   = (N > 1) ? $clog2(N) : 1;
    localparam int RW   = (M > 1) ? $clog2(M) : 1;
    localparam logic signed [EW-1:0] ONE    = 1;
    localparam logic signed [EW-1:0] LIM_HI = (ONE <<< (OW - 1)) - ONE;
    localparam logic signed [EW-1:0] LIM_LO = -(ONE <<< (OW - 1));

    typedef enum logic [1:0] {LOAD_X, LOAD_A, COMPUTE, OUTPUT} state_t;
    state_t state, next;

    logic [CW-1:0]          cnt;
    logic                   a_loaded, reuse_q;
    logic signed [DW-1:0]   x_mem [N];
    logic signed [DW-1:0]   a_mem [MN];
    logic signed [OW-1:0]   y_mem [M];
    logic                   y_ovf [M];
    logic [XW-1:0]          col;
    logic [RW-1:0]          row, p1_row, p2_row, oidx;
    logic signed [DW-1:0]   a_q, x_q;
    logic                   p1_vld, p1_first, p1_last, p2_vld, p2_last;
    logic signed [ACCW-1:0] acc, prod_ext;
    logic signed [2*DW-1:0] prod;
    logic signed [EW-1:0]   acc_x;
    logic signed [OW-1:0]   fmt_val;
    logic                   fmt_ovf;
    logic                   beat, out_hs, reuse_now, issue;

    assign beat   = s_valid && s_ready;
    assign out_hs = m_valid && m_ready;
    // beat 0 decides reuse directly; later beats use the sampled decision
    assign reuse_now = (cnt == '0) ? (reuse_a && a_loaded) : reuse_q;
    assign issue     = (state == COMPUTE) && (cnt < CW'(MN));

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD_X;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            LOAD_X:  if (beat && cnt == CW'(N - 1)) next = reuse_now ? COMPUTE : LOAD_A;
            LOAD_A:  if (beat && cnt == CW'(MN - 1)) next = COMPUTE;
            // last MAC issued at cnt=MN-1: +1 read, +1 accumulate, then y write
            COMPUTE: if (cnt == CW'(MN + 1)) next = OUTPUT;
            OUTPUT:  if (out_hs && oidx == RW'(M - 1)) next = LOAD_X;
            default: next = LOAD_X;
        endcase
    end

    assign prod     = a_q * x_q;
    assign prod_ext = {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};

    always_comb begin
        acc_x   = {{(EW - ACCW){acc[ACCW-1]}}, acc};
        fmt_ovf = 1'b0;
        fmt_val = acc_x[OW-1:0];
        if (acc_x > LIM_HI) begin
            fmt_ovf = 1'b1;
            if (SAT != 0) fmt_val = LIM_HI[OW-1:0];
        end else if (acc_x < LIM_LO) begin
            fmt_ovf = 1'b1;
            if (SAT != 0) fmt_val = LIM_LO[OW-1:0];
        end
    end

    // control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            a_loaded <= 1'b0;
            reuse_q  <= 1'b0;
            col      <= '0;
            row      <= '0;
            p1_vld   <= 1'b0;
            p2_vld   <= 1'b0;
            oidx     <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            data_out <= '0;
            overflow <= 1'b0;
        end else begin
            s_ready <= (next == LOAD_X) || (next == LOAD_A);
            m_valid <= (next == OUTPUT);

            if (next != state)                cnt <= '0;
            else if (beat || state == COMPUTE) cnt <= cnt + 1'b1;

            if (state == LOAD_X && beat && cnt == '0) reuse_q <= reuse_a && a_loaded;
            if (state == LOAD_A && beat && cnt == CW'(MN - 1)) a_loaded <= 1'b1;

            p1_vld <= issue;
            p2_vld <= p1_vld;
            if (issue) begin
                if (col == XW'(N - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (state != COMPUTE) begin
                col <= '0;
                row <= '0;
            end

            if (state == COMPUTE && next == OUTPUT) begin
                oidx <= '0;
                // with M=1 row 0 is being written on this same edge
                if (p2_vld && p2_last && p2_row == '0) begin
                    data_out <= fmt_val;
                    overflow <= fmt_ovf;
                end else begin
                    data_out <= y_mem[0];
                    overflow <= y_ovf[0];
                end
            end else if (state == OUTPUT && out_hs && oidx != RW'(M - 1)) begin
                oidx     <= oidx + 1'b1;
                data_out <= y_mem[oidx + 1'b1];
                overflow <= y_ovf[oidx + 1'b1];
            end
        end
    end

    // operand/result storage and MAC pipeline data (qualified by p*_vld)
    always_ff @(posedge clk) begin
        if (state == LOAD_X && beat) x_mem[cnt[XW-1:0]] <= data_in;
        if (state == LOAD_A && beat) a_mem[cnt[AW-1:0]] <= data_in;
        if (issue) begin
            a_q      <= a_mem[cnt[AW-1:0]];
            x_q      <= x_mem[col];
            p1_first <= (col == '0);
            p1_last  <= (col == XW'(N - 1));
            p1_row   <= row;
        end
        if (p1_vld) begin
            acc     <= (p1_first ? '0 : acc) + prod_ext;
            p2_last <= p1_last;
            p2_row  <= p1_row;
        end
        if (p2_vld && p2_last) begin
            y_mem[p2_row] <= fmt_val;
            y_ovf[p2_row] <= fmt_ovf;
        end
    end
endmodule

// File: tb/tb_mvm_stream_param.sv
// Bench for mvm_stream_param (M=N=3, DW=8, OW=16). Two instances share the
// input stream: dut saturates, dut_w wraps. Table vectors carry constant
// expectations; random frames are scored by a plain-arithmetic model that
// also tracks which A the block should be holding.
module tb_mvm_stream_param;
    localparam int M = 3, N = 3, DW = 8, OW = 16;
    localparam int YMAX = 2 ** (OW - 1) - 1;
    localparam int YMIN = -(2 ** (OW - 1));

    logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, reuse_a = 1'b0, m_ready = 1'b0;
    logic signed [DW-1:0] data_in = '0;
    logic s_ready, m_valid, overflow, w_s_ready, w_m_valid, w_overflow;
    logic signed [OW-1:0] data_out, w_data_out;

    int n_cmp = 0, n_bad = 0, cyc = 0, last_edge = 0;
    int sa[M*N];
    bit a_ok = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mvm_stream_param #(.M(M), .N(N), .DW(DW), .OW(OW), .SAT(1)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .data_in(data_in), .reuse_a(reuse_a), .m_valid(m_valid), .m_ready(m_ready),
        .data_out(data_out), .overflow(overflow));

    mvm_stream_param #(.M(M), .N(N), .DW(DW), .OW(OW), .SAT(0)) dut_w (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(w_s_ready),
        .data_in(data_in), .reuse_a(reuse_a), .m_valid(w_m_valid), .m_ready(m_ready),
        .data_out(w_data_out), .overflow(w_overflow));

    typedef struct packed {
        int x0, x1, x2;
        int amode;      // 0: A = 1..9 row-major, 1: every element = aval
        int aval;
        bit reuse;
        int y0, y1, y2; // saturating instance
        int w0, w1, w2; // wrapping instance
        bit o0, o1, o2; // overflow (same for both modes)
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic die(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting on the DUT (t=%0t)", name, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    endtask

    function automatic void model(input int x[N], input int a[M*N],
                                  output int ey[M], output int eo[M], output int ew[M]);
        for (int i = 0; i < M; i++) begin
            longint s;
            s = 0;
            for (int j = 0; j < N; j++) s += longint'(a[i*N+j]) * longint'(x[j]);
            eo[i] = (s > YMAX || s < YMIN) ? 1 : 0;
            ey[i] = (s > YMAX) ? YMAX : ((s < YMIN) ? YMIN : int'(s));
            ew[i] = int'(s & 64'hFFFF);
            if (ew[i] > YMAX) ew[i] -= 2 ** OW;
        end
    endfunction

    task automatic reset_dut();
        reset = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_w_data_out", w_data_out, 0);
        reset = 1'b0;
        a_ok = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_m_valid", m_valid, 0);
    endtask

    // entered and left at a negedge; last_edge = index of the accepting posedge
    task automatic send_beat(input int v, input bit r, input int gap);
        int g;
        g = 0;
        while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
            s_valid = 1'b0;
            data_in = DW'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1;
        data_in = DW'(v);
        reuse_a = r;
        while (!s_ready) begin
            @(negedge clk);
            g++;
            if (g > 300) die("s_ready_wait");
        end
        @(negedge clk);
        last_edge = cyc;
        s_valid = 1'b0;
        reuse_a = 1'b0;
        data_in = DW'($urandom);
    endtask

    task automatic collect(input int ey[M], input int eo[M], input int ew[M],
                           input int rdy, input int hold_at);
        int  k, g, held;
        bit  first, pend;
        k = 0; g = 0; held = 0; first = 1'b1; pend = 1'b0;
        while (k < M) begin
            // junk beats offered while results drain must be ignored
            s_valid = 1'($urandom_range(0, 1));
            data_in = DW'($urandom);
            reuse_a = 1'($urandom_range(0, 1));
            if (m_valid) begin
                if (first) chk("first_valid_latency", cyc - last_edge, M * N + 2);
                first = 1'b0;
                chk($sformatf("y%0d", k), data_out, ey[k]);
                chk($sformatf("ovf%0d", k), overflow, eo[k]);
                chk($sformatf("wrap_y%0d", k), w_data_out, ew[k]);
                chk($sformatf("wrap_ovf%0d", k), w_overflow, eo[k]);
                chk("s_ready_during_m_valid", s_ready, 0);
                chk("wrap_m_valid", w_m_valid, 1);
                if (k == hold_at && held < 5) begin
                    m_ready = 1'b0;
                    held++;
                end else begin
                    m_ready = (rdy >= 100) || (int'($urandom_range(0, 99)) < rdy);
                end
                pend = !m_ready;
                if (m_ready) k++;
            end else begin
                if (pend) chk("m_valid_held", m_valid, 1);
                pend = 1'b0;
                m_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            g++;
            if (g > 3000) die("m_valid_wait");
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("m_valid_after_last", m_valid, 0);
        chk("s_ready_after_last", s_ready, 1);
    endtask

    task automatic run_frame(input int x[N], input int a[M*N], input bit reuse,
                             input int gap, input int rdy, input int hold_at,
                             input int ey[M], input int eo[M], input int ew[M]);
        bit full;
        full = !(reuse && a_ok);
        for (int j = 0; j < N; j++)
            send_beat(x[j], (j == 0) ? reuse : 1'($urandom_range(0, 1)), gap);
        if (full) begin
            for (int k = 0; k < M * N; k++) send_beat(a[k], 1'($urandom_range(0, 1)), gap);
            sa = a;
            a_ok = 1'b1;
        end
        chk("s_ready_after_frame", s_ready, 0);
        collect(ey, eo, ew, rdy, hold_at);
    endtask

    initial begin
        vec_t tv[6];
        int xb[N], aseq[M*N], a2[M*N], yb[M], zb[M], y12[M];

        tv[0] = '{x0:1,    x1:2,    x2:3,    amode:0, aval:0,    reuse:0,
                  y0:14,    y1:32,    y2:50,    w0:14,     w1:32,     w2:50,     o0:0, o1:0, o2:0};
        tv[1] = '{x0:1,    x1:0,    x2:0,    amode:0, aval:0,    reuse:1,
                  y0:1,     y1:4,     y2:7,     w0:1,      w1:4,      w2:7,      o0:0, o1:0, o2:0};
        tv[2] = '{x0:127,  x1:127,  x2:127,  amode:1, aval:127,  reuse:0,
                  y0:32767, y1:32767, y2:32767, w0:-17149, w1:-17149, w2:-17149, o0:1, o1:1, o2:1};
        tv[3] = '{x0:127,  x1:127,  x2:127,  amode:1, aval:-128, reuse:0,
                  y0:-32768,y1:-32768,y2:-32768,w0:16768,  w1:16768,  w2:16768,  o0:1, o1:1, o2:1};
        tv[4] = '{x0:-128, x1:-128, x2:-128, amode:1, aval:-128, reuse:0,
                  y0:32767, y1:32767, y2:32767, w0:-16384, w1:-16384, w2:-16384, o0:1, o1:1, o2:1};
        tv[5] = '{x0:-1,   x1:2,    x2:-3,   amode:0, aval:0,    reuse:1,
                  y0:256,   y1:256,   y2:256,   w0:256,    w1:256,    w2:256,    o0:0, o1:0, o2:0};

        reset_dut();

        for (int t = 0; t < 6; t++) begin
            int x[N], a[M*N], ey[M], eo[M], ew[M];
            x  = '{tv[t].x0, tv[t].x1, tv[t].x2};
            for (int k = 0; k < M * N; k++) a[k] = (tv[t].amode != 0) ? tv[t].aval : k + 1;
            ey = '{tv[t].y0, tv[t].y1, tv[t].y2};
            ew = '{tv[t].w0, tv[t].w1, tv[t].w2};
            eo = '{int'(tv[t].o0), int'(tv[t].o1), int'(tv[t].o2)};
            run_frame(x, a, tv[t].reuse, 0, 100, -1, ey, eo, ew);
        end

        xb = '{1, 2, 3};
        for (int k = 0; k < M * N; k++) begin
            aseq[k] = k + 1;
            a2[k]   = 2;
        end
        yb  = '{14, 32, 50};
        zb  = '{0, 0, 0};
        y12 = '{12, 12, 12};

        // input gaps and random output backpressure
        run_frame(xb, aseq, 1'b0, 40, 50, -1, yb, zb, yb);
        // reuse frame with y[1]=32 held under m_ready=0 for 5 cycles
        run_frame(xb, aseq, 1'b1, 0, 100, 1, yb, zb, yb);

        // reset in the middle of an A load, then a reuse request must reload A
        for (int j = 0; j < N; j++) send_beat(xb[j], 1'b0, 0);
        for (int k = 0; k < 4; k++) send_beat(100, 1'b0, 0);
        reset_dut();
        run_frame(xb, a2, 1'b1, 20, 70, -1, y12, zb, y12);

        for (int f = 0; f < 25; f++) begin
            int x[N], a[M*N], ey[M], eo[M], ew[M];
            int amp;
            bit r;
            amp = (f % 3 == 0) ? 128 : 16;
            for (int j = 0; j < N; j++) x[j] = int'($urandom_range(0, 2 * amp - 1)) - amp;
            for (int k = 0; k < M * N; k++) a[k] = int'($urandom_range(0, 2 * amp - 1)) - amp;
            r = 1'($urandom_range(0, 1));
            if (r && a_ok) model(x, sa, ey, eo, ew);
            else           model(x, a, ey, eo, ew);
            run_frame(x, a, r, 30, 60, -1, ey, eo, ew);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
